// File: rtl/hilo_unit.sv
// HI/LO sequencing stage around an external combinational 32x32 multiplier.
// It registers the operands, waits MUL_LATENCY cycles, then commits the sign-corrected product.
module hilo_unit #(
    parameter int unsigned MUL_LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        mul_ena,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic [63:0] mul_z,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_MTHI  = 2'b10;
    localparam logic [1:0] OP_MTLO  = 2'b11;
    localparam logic [3:0] CNT_INIT = 4'(MUL_LATENCY);

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        neg_q, neg_d;
    logic        done_q, done_d;
    logic [31:0] mul_a_q, mul_a_d;
    logic [31:0] mul_b_q, mul_b_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic [31:0] rs_mag;
    logic [31:0] rt_mag;
    logic [63:0] product_fix;

    // 0x80000000 negates to itself, which is its correct unsigned magnitude.
    assign rs_mag      = rs_data[31] ? (~rs_data + 32'd1) : rs_data;
    assign rt_mag      = rt_data[31] ? (~rt_data + 32'd1) : rt_data;
    assign product_fix = neg_q ? (~mul_z + 64'd1) : mul_z;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        done_d  = 1'b0;
        mul_a_d = mul_a_q;
        mul_b_d = mul_b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    case (op)
                        OP_MULTU: begin
                            mul_a_d = rs_data;
                            mul_b_d = rt_data;
                            neg_d   = 1'b0;
                            cnt_d   = CNT_INIT;
                            state_d = WAIT;
                        end
                        OP_MULT: begin
                            mul_a_d = rs_mag;
                            mul_b_d = rt_mag;
                            neg_d   = rs_data[31] ^ rt_data[31];
                            cnt_d   = CNT_INIT;
                            state_d = WAIT;
                        end
                        OP_MTHI: begin
                            hi_d   = rs_data;
                            done_d = 1'b1;
                        end
                        OP_MTLO: begin
                            lo_d   = rs_data;
                            done_d = 1'b1;
                        end
                        default: begin
                            state_d = IDLE;
                        end
                    endcase
                end
            end
            WAIT: begin
                // New requests are dropped here; the control FSM stalls on busy.
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    {hi_d, lo_d} = product_fix;
                    done_d       = 1'b1;
                    cnt_d        = 4'd0;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            neg_q   <= 1'b0;
            done_q  <= 1'b0;
            mul_a_q <= 32'd0;
            mul_b_q <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            done_q  <= done_d;
            mul_a_q <= mul_a_d;
            mul_b_q <= mul_b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy    = (state_q == WAIT);
    assign mul_ena = (state_q == WAIT);
    assign mul_a   = mul_a_q;
    assign mul_b   = mul_b_q;
    assign done    = done_q;
    assign hi      = hi_q;
    assign lo      = lo_q;

endmodule

// File: tb/tb_hilo_unit.sv
// Directed self-checking bench for hilo_unit with a behavioural multiplier
// that only produces a product while mul_ena is asserted.
module tb_hilo_unit;

    localparam int LAT = 2;

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_MTHI  = 2'b10;
    localparam logic [1:0] OP_MTLO  = 2'b11;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        mul_ena;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic [63:0] mul_z;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks;
    int failures;

    hilo_unit #(.MUL_LATENCY(LAT)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .mul_ena (mul_ena),
        .mul_a   (mul_a),
        .mul_b   (mul_b),
        .mul_z   (mul_z),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    assign mul_z = mul_ena ? ({32'd0, mul_a} * {32'd0, mul_b}) : 64'd0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Drives one request across a rising edge (E0) and leaves the bench 1 time unit after it.
    task automatic applyStimulus(input logic [1:0] o, input logic [31:0] rs, input logic [31:0] rt);
        start   = 1'b1;
        op      = o;
        rs_data = rs;
        rt_data = rt;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic runMul(input string tag, input logic [1:0] o,
                          input logic [31:0] rs, input logic [31:0] rt,
                          input logic [31:0] exp_a, input logic [31:0] exp_b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int busy_cycles;
        int lat;
        bit found;
        busy_cycles = 0;
        lat         = 0;
        found       = 1'b0;
        applyStimulus(o, rs, rt);
        checkOutput({tag, "_busy_e0"}, 64'(busy), 64'd1);
        checkOutput({tag, "_ena_e0"}, 64'(mul_ena), 64'd1);
        checkOutput({tag, "_done_e0"}, 64'(done), 64'd0);
        checkOutput({tag, "_mul_a"}, 64'(mul_a), 64'(exp_a));
        checkOutput({tag, "_mul_b"}, 64'(mul_b), 64'(exp_b));
        for (int c = 1; c <= 20; c++) begin
            if (busy) busy_cycles++;
            @(posedge clk);
            #1;
            if (done) begin
                found = 1'b1;
                lat   = c;
                break;
            end
        end
        checkOutput({tag, "_done_seen"}, 64'(found), 64'd1);
        checkOutput({tag, "_latency"}, 64'(lat), 64'(LAT));
        checkOutput({tag, "_busy_cycles"}, 64'(busy_cycles), 64'(LAT));
        checkOutput({tag, "_busy_after"}, 64'(busy), 64'd0);
        checkOutput({tag, "_hi"}, 64'(hi), 64'(exp_hi));
        checkOutput({tag, "_lo"}, 64'(lo), 64'(exp_lo));
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        start    = 1'b0;
        op       = 2'b00;
        rs_data  = 32'd0;
        rt_data  = 32'd0;

        #7;
        checkOutput("rst_hi", 64'(hi), 64'd0);
        checkOutput("rst_lo", 64'(lo), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        checkOutput("rst_ena", 64'(mul_ena), 64'd0);
        checkOutput("rst_mul_a", 64'(mul_a), 64'd0);
        #5;
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Back-to-back multiplies: each new start lands in the first IDLE cycle.
        runMul("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        runMul("mult_neg", OP_MULT, 32'hFFFF_FFFD, 32'd5,
               32'd3, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        runMul("mult_min", OP_MULT, 32'h8000_0000, 32'h8000_0000,
               32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
        runMul("mult_zero", OP_MULT, 32'd0, 32'hFFFF_FFFF,
               32'd0, 32'd1, 32'd0, 32'd0);
        runMul("mult_pos_neg", OP_MULT, 32'd7, 32'hFFFF_FFFE,
               32'd7, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFF2);

        // MTHI then MTLO on consecutive cycles.
        start   = 1'b1;
        op      = OP_MTHI;
        rs_data = 32'h1234_5678;
        @(posedge clk);
        #1;
        checkOutput("mthi_hi", 64'(hi), 64'h1234_5678);
        checkOutput("mthi_done", 64'(done), 64'd1);
        checkOutput("mthi_busy", 64'(busy), 64'd0);
        op      = OP_MTLO;
        rs_data = 32'h9ABC_DEF0;
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("mtlo_lo", 64'(lo), 64'h9ABC_DEF0);
        checkOutput("mtlo_hi_kept", 64'(hi), 64'h1234_5678);
        checkOutput("mtlo_done", 64'(done), 64'd1);
        checkOutput("mtlo_busy", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        checkOutput("mt_done_drop", 64'(done), 64'd0);

        // MTLO arriving during WAIT is dropped.
        applyStimulus(OP_MULTU, 32'd7, 32'd6);
        start   = 1'b1;
        op      = OP_MTLO;
        rs_data = 32'h0000_DEAD;
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("ign_lo_held", 64'(lo), 64'h9ABC_DEF0);
        checkOutput("ign_hi_held", 64'(hi), 64'h1234_5678);
        checkOutput("ign_busy", 64'(busy), 64'd1);
        checkOutput("ign_done_low", 64'(done), 64'd0);
        @(posedge clk);
        #1;
        checkOutput("ign_done", 64'(done), 64'd1);
        checkOutput("ign_lo", 64'(lo), 64'd42);
        checkOutput("ign_hi", 64'(hi), 64'd0);
        @(posedge clk);
        #1;
        checkOutput("ign_lo_final", 64'(lo), 64'd42);
        checkOutput("ign_busy_final", 64'(busy), 64'd0);

        // Asynchronous reset in the middle of a multiply.
        applyStimulus(OP_MTHI, 32'h0000_CAFE, 32'd0);
        checkOutput("pre_rst_hi", 64'(hi), 64'h0000_CAFE);
        applyStimulus(OP_MULTU, 32'd3, 32'd3);
        checkOutput("pre_rst_busy", 64'(busy), 64'd1);
        #3;
        reset = 1'b0;
        #1;
        checkOutput("arst_hi", 64'(hi), 64'd0);
        checkOutput("arst_lo", 64'(lo), 64'd0);
        checkOutput("arst_busy", 64'(busy), 64'd0);
        checkOutput("arst_done", 64'(done), 64'd0);
        checkOutput("arst_ena", 64'(mul_ena), 64'd0);
        checkOutput("arst_mul_a", 64'(mul_a), 64'd0);
        checkOutput("arst_mul_b", 64'(mul_b), 64'd0);
        #2;
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("post_rst_done", 64'(done), 64'd0);
        checkOutput("post_rst_lo", 64'(lo), 64'd0);
        runMul("post_rst", OP_MULTU, 32'h0001_0000, 32'h0001_0000,
               32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
